genbus_fabric: RTL and testbench

Parametrised successor to the single-master dbus: a multi-master, multi-slave generic-bus fabric. It performs round-robin arbitration between NMASTERS requesters and decodes the top address bits to one of NSLAVES slaves. It forwards one transaction at a time, returns read data and a completion ack, and signals an error for unmapped addresses and for slave timeouts. It sits between the CPU/DMA masters and the peripheral slaves (ports, ac, ...) at chip level.

---
 rtl/genbus_fabric.sv | 149 ++++++++++++++
 tb/tb_genbus_fabric.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/genbus_fabric.sv
// Multi-master, multi-slave generic bus fabric.
// Round-robin arbitration, top-bit address decode, one transaction in flight.
module genbus_fabric #(
  parameter int NMASTERS = 2,
  parameter int NSLAVES  = 2,
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int SELW     = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NMASTERS-1:0]    m_req,
  input  logic [NMASTERS-1:0]    m_we,
  input  logic [NMASTERS*AW-1:0] m_addr,
  input  logic [NMASTERS*DW-1:0] m_wdata,
  output logic [NMASTERS-1:0]    m_ack,
  output logic [NMASTERS-1:0]    m_err,
  output logic [DW-1:0]          m_rdata,
  output logic [NSLAVES-1:0]     s_sel,
  output logic                   s_we,
  output logic [AW-1:0]          s_addr,
  output logic [DW-1:0]          s_wdata,
  input  logic [NSLAVES*DW-1:0]  s_rdata,
  input  logic [NSLAVES-1:0]     s_rdy,
  output logic                   busy,
  output logic [(NMASTERS>1 ? $clog2(NMASTERS) : 1)-1:0] grant_id
);

  localparam int GW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e              state_q;
  logic [GW-1:0]       last_q;
  logic [GW-1:0]       grant_q;
  logic [SELW-1:0]     idx_q;
  logic [7:0]          cnt_q;
  logic [NSLAVES-1:0]  s_sel_q;
  logic                s_we_q;
  logic [AW-1:0]       s_addr_q;
  logic [DW-1:0]       s_wdata_q;
  logic [NMASTERS-1:0] m_ack_q;
  logic [NMASTERS-1:0] m_err_q;
  logic [DW-1:0]       m_rdata_q;

  logic                found;
  logic [GW-1:0]       gnt;
  logic [AW-1:0]       gaddr;
  logic [SELW-1:0]     gidx;
  logic                rdy_sel;
  logic [DW-1:0]       rdata_sel;

  // First requester at or after last+1, wrapping.
  always_comb begin
    found = 1'b0;
    gnt   = last_q;
    for (int k = 1; k <= NMASTERS; k++) begin
      if (!found && m_req[(int'(last_q) + k) % NMASTERS]) begin
        found = 1'b1;
        gnt   = GW'((int'(last_q) + k) % NMASTERS);
      end
    end
    gaddr = m_addr[gnt*AW +: AW];
    gidx  = gaddr[AW-1 -: SELW];
  end

  assign rdy_sel   = s_rdy[idx_q];
  assign rdata_sel = s_rdata[idx_q*DW +: DW];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_q    <= GW'(NMASTERS-1);
      grant_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      s_sel_q   <= '0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      m_ack_q   <= '0;
      m_err_q   <= '0;
      m_rdata_q <= '0;
    end else begin
      m_ack_q <= '0;
      m_err_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (found) begin
            grant_q   <= gnt;
            last_q    <= gnt;
            s_we_q    <= m_we[gnt];
            s_addr_q  <= gaddr;
            s_wdata_q <= m_wdata[gnt*DW +: DW];
            idx_q     <= gidx;
            cnt_q     <= '0;
            if (int'(gidx) < NSLAVES) begin
              s_sel_q <= NSLAVES'(1) << gidx;
              state_q <= ACCESS;
            end else begin
              m_ack_q   <= NMASTERS'(1) << gnt;
              m_err_q   <= NMASTERS'(1) << gnt;
              m_rdata_q <= '0;
              state_q   <= RESP;
            end
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + 8'd1;
          // Ready beats timeout when both land on the same cycle.
          if (rdy_sel) begin
            m_ack_q   <= NMASTERS'(1) << grant_q;
            m_rdata_q <= rdata_sel;
            s_sel_q   <= '0;
            state_q   <= RESP;
          end else if (cnt_q == 8'(TIMEOUT-1)) begin
            m_ack_q   <= NMASTERS'(1) << grant_q;
            m_err_q   <= NMASTERS'(1) << grant_q;
            m_rdata_q <= '0;
            s_sel_q   <= '0;
            state_q   <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_ack    = m_ack_q;
  assign m_err    = m_err_q;
  assign m_rdata  = m_rdata_q;
  assign s_sel    = s_sel_q;
  assign s_we     = s_we_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_genbus_fabric.sv
// Testbench for genbus_fabric: directed vector table, reset abort,
// and randomized transactions against a transaction-level model.
module tb_genbus_fabric;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_req, m_we, m_ack, m_err, s_sel, s_rdy;
  logic [15:0] m_addr, m_wdata, s_rdata;
  logic [7:0]  m_rdata, s_addr, s_wdata;
  logic        s_we, busy;
  logic [0:0]  grant_id;

  int pass_n  = 0;
  int total_n = 0;
  int last_g  = 1;

  always #5 clk = ~clk;

  genbus_fabric dut (
    .clk      (clk),
    .rst      (rst_n),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ack    (m_ack),
    .m_err    (m_err),
    .m_rdata  (m_rdata),
    .s_sel    (s_sel),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .s_rdy    (s_rdy),
    .busy     (busy),
    .grant_id (grant_id)
  );

  // d: 1-based ACCESS cycle on which the selected slave is ready (0 = never)
  // acc: expected ACCESS length (0 = unmapped, ack straight after grant)
  typedef struct {
    logic [1:0] req;
    logic [1:0] we;
    logic [7:0] a0, a1, w0, w1;
    int         d;
    logic [7:0] rd;
    int         gnt;
    int         acc;
    logic       err;
    logic [7:0] erd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total_n++;
    if (a === e) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  task automatic run(input vec_t v);
    logic [7:0] ga, gw;
    int         idx;
    logic [1:0] oh, soh;
    m_req   = v.req;
    m_we    = v.we;
    m_addr  = {v.a1, v.a0};
    m_wdata = {v.w1, v.w0};
    s_rdy   = 2'b00;
    ga  = (v.gnt == 1) ? v.a1 : v.a0;
    gw  = (v.gnt == 1) ? v.w1 : v.w0;
    idx = int'(ga[7:6]);
    oh  = 2'(1 << v.gnt);
    soh = 2'(1 << idx);
    s_rdata = (idx == 1) ? {v.rd, ~v.rd} : {~v.rd, v.rd};
    @(posedge clk); #1;
    chk("grant_id", 32'(grant_id), 32'(v.gnt));
    if (v.acc == 0) begin
      chk("unmapped_ack", {s_sel, m_ack, m_err}, {2'b00, oh, oh});
      chk("unmapped_rdata", 32'(m_rdata), 32'h0);
    end else begin
      chk("fwd", {s_sel, s_we, s_addr, s_wdata, busy},
          {soh, v.we[v.gnt], ga, gw, 1'b1});
      m_addr  = 16'($urandom);
      m_wdata = 16'($urandom);
      for (int n = 1; n <= v.acc; n++) begin
        s_rdy = (idx == 0) ? {1'b1, n == v.d} : {n == v.d, 1'b1};
        @(posedge clk); #1;
        if (n < v.acc) begin
          chk("access", {s_sel, m_ack}, {soh, 2'b00});
        end else begin
          chk("ack", {s_sel, m_ack, m_err},
              {2'b00, oh, v.err ? oh : 2'b00});
          chk("rdata", 32'(m_rdata), 32'(v.erd));
        end
      end
    end
    s_rdy = 2'b00;
    m_req[v.gnt] = 1'b0;
    last_g = v.gnt;
    @(posedge clk); #1;
    chk("idle", {busy, m_ack}, 32'h0);
  endtask

  // Transaction-level reference: round-robin pick, decode, ready/timeout.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic [7:0] ga;
    int idx;
    for (int k = 2; k >= 1; k--)
      if (v.req[(last_g + k) % 2]) r.gnt = (last_g + k) % 2;
    ga  = (r.gnt == 1) ? v.a1 : v.a0;
    idx = int'(ga) / 64;
    if (idx >= 2) begin
      r.acc = 0; r.err = 1'b1; r.erd = 8'h00;
    end else if (v.d >= 1 && v.d <= 15) begin
      r.acc = v.d; r.err = 1'b0; r.erd = v.rd;
    end else begin
      r.acc = 15; r.err = 1'b1; r.erd = 8'h00;
    end
    return r;
  endfunction

  vec_t tbl[10];
  vec_t rv;

  initial begin
    tbl[0] = '{2'b01, 2'b00, 8'h45, 8'h00, 8'h11, 8'h22, 1, 8'hA5, 0, 1, 1'b0, 8'hA5};
    tbl[1] = '{2'b10, 2'b10, 8'h00, 8'hC0, 8'h00, 8'h5A, 1, 8'h00, 1, 0, 1'b1, 8'h00};
    tbl[2] = '{2'b11, 2'b00, 8'h10, 8'h50, 8'h01, 8'h02, 1, 8'h31, 0, 1, 1'b0, 8'h31};
    tbl[3] = '{2'b11, 2'b00, 8'h10, 8'h50, 8'h01, 8'h02, 1, 8'h32, 1, 1, 1'b0, 8'h32};
    tbl[4] = '{2'b11, 2'b00, 8'h10, 8'h50, 8'h01, 8'h02, 1, 8'h33, 0, 1, 1'b0, 8'h33};
    tbl[5] = '{2'b11, 2'b00, 8'h10, 8'h50, 8'h01, 8'h02, 1, 8'h34, 1, 1, 1'b0, 8'h34};
    tbl[6] = '{2'b01, 2'b00, 8'h05, 8'h00, 8'h00, 8'h00, 0, 8'h77, 0, 15, 1'b1, 8'h00};
    tbl[7] = '{2'b01, 2'b00, 8'h07, 8'h00, 8'h00, 8'h00, 15, 8'h3C, 0, 15, 1'b0, 8'h3C};
    tbl[8] = '{2'b10, 2'b10, 8'h00, 8'h7F, 8'h00, 8'hE7, 3, 8'h99, 1, 3, 1'b0, 8'h99};
    tbl[9] = '{2'b01, 2'b01, 8'h9A, 8'h00, 8'h6B, 8'h00, 1, 8'h00, 0, 0, 1'b1, 8'h00};

    rst_n = 1'b0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    s_rdata = '0; s_rdy = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", {m_ack, m_err, m_rdata, s_sel, s_we, busy, grant_id}, 32'h0);
    chk("reset_b", {s_addr, s_wdata}, 32'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) run(tbl[i]);

    // Reset during the second ACCESS cycle aborts without an ack.
    m_req = 2'b01; m_addr = 16'h0005; s_rdy = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_access", 32'(s_sel), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_a", {m_ack, m_err, m_rdata, s_sel, s_we, busy, grant_id}, 32'h0);
    chk("abort_b", {s_addr, s_wdata}, 32'h0);
    m_req = 2'b00;
    @(posedge clk); #1;
    chk("abort_noack", {m_ack, busy}, 32'h0);
    rst_n = 1'b1;
    last_g = 1;
    rv = '{2'b11, 2'b00, 8'h20, 8'h60, 8'h00, 8'h00, 1, 8'h4E, 0, 1, 1'b0, 8'h4E};
    run(rv);

    for (int t = 0; t < 40; t++) begin
      rv.req = 2'($urandom_range(1, 3));
      rv.we  = 2'($urandom);
      rv.a0  = 8'($urandom);
      rv.a1  = 8'($urandom);
      rv.w0  = 8'($urandom);
      rv.w1  = 8'($urandom);
      rv.d   = $urandom_range(0, 17);
      rv.rd  = 8'($urandom);
      run(model(rv));
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
